// File: rtl/mips_writeback.sv
// MEM/WB pipeline register and write-back mux. It drives the register file write port.
// Optional retire counter: define MIPS_WB_RETIRE_CNT_EN to build it; otherwise retire_count is tied to 0.
module mips_writeback #(
    parameter int BIG_ENDIAN = 1,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             flush,
    input  logic             mem_valid,
    input  logic             mem_regwrite,
    input  logic [4:0]       mem_rd,
    input  logic [1:0]       mem_wbsel,
    input  logic [2:0]       mem_load_type,
    input  logic [31:0]      mem_alu_result,
    input  logic [31:0]      mem_load_data,
    input  logic [31:0]      mem_pc_plus8,
    output logic [4:0]       reg_write,
    output logic [31:0]      wdata,
    output logic             write,
    output logic             wb_valid,
    output logic             wb_exc,
    output logic [CNT_W-1:0] retire_count
);
    localparam logic [2:0] LT_LH  = 3'b001;
    localparam logic [2:0] LT_LHU = 3'b010;
    localparam logic [2:0] LT_LB  = 3'b011;
    localparam logic [2:0] LT_LBU = 3'b100;

    localparam logic [1:0] SEL_LOAD = 2'b01;
    localparam logic [1:0] SEL_LINK = 2'b10;

    logic        vld_p0;
    logic        regwrite_p0;
    logic [4:0]  rd_p0;
    logic [1:0]  wbsel_p0;
    logic [2:0]  load_type_p0;
    logic [31:0] alu_p0;
    logic [31:0] ldata_p0;
    logic [31:0] pc8_p0;

    function automatic logic [7:0] byte_lane(input logic [31:0] w, input logic [1:0] off);
        logic [1:0] idx;
        logic [7:0] b;
        // Big-endian puts offset 0 in the top lane, so the lane index is the inverted offset.
        idx = (BIG_ENDIAN != 0) ? ~off : off;
        case (idx)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        return b;
    endfunction

    function automatic logic [15:0] half_lane(input logic [31:0] w, input logic off_hi);
        logic hi;
        hi = (BIG_ENDIAN != 0) ? ~off_hi : off_hi;
        return hi ? w[31:16] : w[15:0];
    endfunction

    function automatic logic [31:0] ext8(input logic [7:0] b, input logic sgn);
        logic signed [7:0] sb;
        sb = b;
        return sgn ? 32'(sb) : {24'b0, b};
    endfunction

    function automatic logic [31:0] ext16(input logic [15:0] h, input logic sgn);
        logic signed [15:0] sh;
        sh = h;
        return sgn ? 32'(sh) : {16'b0, h};
    endfunction

    // ---- MEM -> WB register ----
    always_ff @(posedge clk) begin
        if (rst || stall || flush) begin
            vld_p0       <= 1'b0;
            regwrite_p0  <= 1'b0;
            rd_p0        <= '0;
            wbsel_p0     <= '0;
            load_type_p0 <= '0;
            alu_p0       <= '0;
            ldata_p0     <= '0;
            pc8_p0       <= '0;
        end else begin
            vld_p0       <= mem_valid;
            regwrite_p0  <= mem_regwrite;
            rd_p0        <= mem_rd;
            wbsel_p0     <= mem_wbsel;
            load_type_p0 <= mem_load_type;
            alu_p0       <= mem_alu_result;
            ldata_p0     <= mem_load_data;
            pc8_p0       <= mem_pc_plus8;
        end
    end

    // ---- WB combinational write port ----
    logic [1:0]  off;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_val;
    logic        misaligned;

    assign off      = alu_p0[1:0];
    assign byte_sel = byte_lane(ldata_p0, off);
    assign half_sel = half_lane(ldata_p0, off[1]);

    always_comb begin
        load_val   = ldata_p0;
        misaligned = (off != 2'b00);
        case (load_type_p0)
            LT_LH: begin
                load_val   = ext16(half_sel, 1'b1);
                misaligned = off[0];
            end
            LT_LHU: begin
                load_val   = ext16(half_sel, 1'b0);
                misaligned = off[0];
            end
            LT_LB: begin
                load_val   = ext8(byte_sel, 1'b1);
                misaligned = 1'b0;
            end
            LT_LBU: begin
                load_val   = ext8(byte_sel, 1'b0);
                misaligned = 1'b0;
            end
            default: begin
                load_val   = ldata_p0;
                misaligned = (off != 2'b00);
            end
        endcase
    end

    always_comb begin
        wdata = '0;
        if (vld_p0) begin
            case (wbsel_p0)
                SEL_LOAD: wdata = load_val;
                SEL_LINK: wdata = pc8_p0;
                default:  wdata = alu_p0;
            endcase
        end
    end

    assign wb_valid  = vld_p0;
    assign wb_exc    = vld_p0 && (wbsel_p0 == SEL_LOAD) && misaligned;
    assign reg_write = rd_p0;
    assign write     = vld_p0 && regwrite_p0 && (rd_p0 != 5'd0) && !wb_exc;

`ifdef MIPS_WB_RETIRE_CNT_EN
    logic [CNT_W-1:0] cnt_p1;

    // ---- retire counter ----
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_p1 <= '0;
        end else if (vld_p0 && !wb_exc) begin
            cnt_p1 <= cnt_p1 + CNT_W'(1);
        end
    end

    assign retire_count = cnt_p1;
`else
    assign retire_count = '0;
`endif

endmodule

// File: tb/tb_mips_writeback.sv
// Scoreboard bench for mips_writeback: a big-endian 32-bit-counter instance and a
// little-endian 2-bit-counter instance share one stimulus stream.
`timescale 1ns/1ps
module tb_mips_writeback;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, stall, flush, mem_valid, mem_regwrite;
    logic [4:0]  mem_rd;
    logic [1:0]  mem_wbsel;
    logic [2:0]  mem_load_type;
    logic [31:0] mem_alu_result, mem_load_data, mem_pc_plus8;

    logic [4:0]  reg_write_a, reg_write_b;
    logic [31:0] wdata_a, wdata_b;
    logic        write_a, write_b, wb_valid_a, wb_valid_b, wb_exc_a, wb_exc_b;
    logic [31:0] retire_count_a;
    logic [1:0]  retire_count_b;

    mips_writeback #(.BIG_ENDIAN(1), .CNT_W(32)) dut_a (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .mem_valid(mem_valid), .mem_regwrite(mem_regwrite), .mem_rd(mem_rd),
        .mem_wbsel(mem_wbsel), .mem_load_type(mem_load_type),
        .mem_alu_result(mem_alu_result), .mem_load_data(mem_load_data),
        .mem_pc_plus8(mem_pc_plus8),
        .reg_write(reg_write_a), .wdata(wdata_a), .write(write_a),
        .wb_valid(wb_valid_a), .wb_exc(wb_exc_a), .retire_count(retire_count_a)
    );

    mips_writeback #(.BIG_ENDIAN(0), .CNT_W(2)) dut_b (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .mem_valid(mem_valid), .mem_regwrite(mem_regwrite), .mem_rd(mem_rd),
        .mem_wbsel(mem_wbsel), .mem_load_type(mem_load_type),
        .mem_alu_result(mem_alu_result), .mem_load_data(mem_load_data),
        .mem_pc_plus8(mem_pc_plus8),
        .reg_write(reg_write_b), .wdata(wdata_b), .write(write_b),
        .wb_valid(wb_valid_b), .wb_exc(wb_exc_b), .retire_count(retire_count_b)
    );

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] wdata_a;
        logic [31:0] wdata_b;
        logic        write;
        logic        valid;
        logic        exc;
        logic [31:0] cnt_a;
        logic [1:0]  cnt_b;
    } exp_t;

    exp_t        sb[$];
    int          passed = 0;
    int          total  = 0;
    int          cyc    = 0;
    logic [31:0] m_cnt_a = '0;
    logic [1:0]  m_cnt_b = '0;
    logic        m_ret   = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs === exp) passed++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    endtask

    // Reference extraction: shift the word down to the addressed lane.
    function automatic logic [31:0] model_load(input logic [31:0] data, input logic [31:0] addr,
                                               input logic [2:0] lt, input bit be);
        int bsel, hsel;
        logic [7:0]  b;
        logic [15:0] h;
        bsel = be ? 3 - int'(addr[1:0]) : int'(addr[1:0]);
        hsel = be ? 1 - int'(addr[1])   : int'(addr[1]);
        b = 8'(data >> (8 * bsel));
        h = 16'(data >> (16 * hsel));
        case (lt)
            3'd1:    return {{16{h[15]}}, h};
            3'd2:    return {16'h0, h};
            3'd3:    return {{24{b[7]}}, b};
            3'd4:    return {24'h0, b};
            default: return data;
        endcase
    endfunction

    task automatic drive(input logic r, input logic s, input logic f, input logic v,
                         input logic rw, input logic [4:0] rd, input logic [1:0] sel,
                         input logic [2:0] lt, input logic [31:0] alu,
                         input logic [31:0] ld, input logic [31:0] pc8);
        exp_t e, o;
        logic bub, val, mis;
        rst = r; stall = s; flush = f; mem_valid = v; mem_regwrite = rw; mem_rd = rd;
        mem_wbsel = sel; mem_load_type = lt; mem_alu_result = alu;
        mem_load_data = ld; mem_pc_plus8 = pc8;

        bub = r | s | f;
        val = !bub && v;
        if (lt == 3'd1 || lt == 3'd2)      mis = alu[0];
        else if (lt == 3'd3 || lt == 3'd4) mis = 1'b0;
        else                               mis = (alu[1:0] != 2'b00);

        if (r) begin
            m_cnt_a = '0;
            m_cnt_b = '0;
        end else if (m_ret) begin
            m_cnt_a = m_cnt_a + 32'd1;
            m_cnt_b = m_cnt_b + 2'd1;
        end

        e.exc   = val && (sel == 2'b01) && mis;
        e.valid = val;
        e.rd    = bub ? 5'd0 : rd;
        if (!val) begin
            e.wdata_a = '0;
            e.wdata_b = '0;
        end else if (sel == 2'b01) begin
            e.wdata_a = model_load(ld, alu, lt, 1'b1);
            e.wdata_b = model_load(ld, alu, lt, 1'b0);
        end else if (sel == 2'b10) begin
            e.wdata_a = pc8;
            e.wdata_b = pc8;
        end else begin
            e.wdata_a = alu;
            e.wdata_b = alu;
        end
        e.write = val && rw && (rd != 5'd0) && !e.exc;
        m_ret   = val && !e.exc;
`ifdef MIPS_WB_RETIRE_CNT_EN
        e.cnt_a = m_cnt_a;
        e.cnt_b = m_cnt_b;
`else
        e.cnt_a = '0;
        e.cnt_b = '0;
`endif
        sb.push_back(e);

        @(posedge clk);
        #1;
        cyc++;
        o = sb.pop_front();
        chk($sformatf("c%0d.reg_write", cyc), 32'(reg_write_a), 32'(o.rd));
        chk($sformatf("c%0d.wdata_be", cyc), wdata_a, o.wdata_a);
        chk($sformatf("c%0d.wdata_le", cyc), wdata_b, o.wdata_b);
        chk($sformatf("c%0d.write", cyc), 32'(write_a), 32'(o.write));
        chk($sformatf("c%0d.wb_valid", cyc), 32'(wb_valid_a), 32'(o.valid));
        chk($sformatf("c%0d.wb_exc", cyc), 32'(wb_exc_a), 32'(o.exc));
        chk($sformatf("c%0d.retire32", cyc), retire_count_a, o.cnt_a);
        chk($sformatf("c%0d.retire2", cyc), 32'(retire_count_b), 32'(o.cnt_b));
    endtask

    task automatic bubble();
        drive(0, 0, 0, 0, 0, 5'd0, 2'b00, 3'd0, 32'h0, 32'h0, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        #1;
        // reset state
        drive(1, 0, 0, 1, 1, 5'd3, 2'b00, 3'd0, 32'hDEAD_BEEF, 32'h0, 32'h0);
        drive(1, 0, 0, 0, 0, 5'd0, 2'b00, 3'd0, 32'h0, 32'h0, 32'h0);

        // ALU write followed by a bubble
        drive(0, 0, 0, 1, 1, 5'd5, 2'b00, 3'd0, 32'h0000_1234, 32'h0, 32'h0);
        bubble();
        drive(0, 0, 0, 1, 1, 5'd6, 2'b11, 3'd0, 32'h0000_5678, 32'h0, 32'h0);

        // sub-word loads on 0x80FF_7F01
        drive(0, 0, 0, 1, 1, 5'd8, 2'b01, 3'd3, 32'h0000_0100, 32'h80FF_7F01, 32'h0);
        drive(0, 0, 0, 1, 1, 5'd8, 2'b01, 3'd4, 32'h0000_0101, 32'h80FF_7F01, 32'h0);
        drive(0, 0, 0, 1, 1, 5'd8, 2'b01, 3'd1, 32'h0000_0102, 32'h80FF_7F01, 32'h0);
        drive(0, 0, 0, 1, 1, 5'd8, 2'b01, 3'd2, 32'h0000_0100, 32'h80FF_7F01, 32'h0);
        drive(0, 0, 0, 1, 1, 5'd8, 2'b01, 3'd0, 32'h0000_0104, 32'h80FF_7F01, 32'h0);
        drive(0, 0, 0, 1, 1, 5'd8, 2'b01, 3'd3, 32'h0000_0103, 32'h80FF_7F01, 32'h0);
        drive(0, 0, 0, 1, 1, 5'd8, 2'b01, 3'd6, 32'h0000_0108, 32'h1234_5678, 32'h0);

        // misaligned loads
        drive(0, 0, 0, 1, 1, 5'd7, 2'b01, 3'd0, 32'h0000_0102, 32'h80FF_7F01, 32'h0);
        drive(0, 0, 0, 1, 1, 5'd7, 2'b01, 3'd1, 32'h0000_0103, 32'h80FF_7F01, 32'h0);
        drive(0, 0, 0, 1, 1, 5'd7, 2'b01, 3'd2, 32'h0000_0101, 32'h80FF_7F01, 32'h0);
        bubble();

        // link and r0
        drive(0, 0, 0, 1, 1, 5'd31, 2'b10, 3'd0, 32'h0, 32'h0, 32'h0040_0008);
        drive(0, 0, 0, 1, 1, 5'd0, 2'b10, 3'd0, 32'h0, 32'h0, 32'h0040_0008);
        bubble();

        // stall / flush
        drive(0, 1, 0, 1, 1, 5'd12, 2'b00, 3'd0, 32'hCAFE_0001, 32'h0, 32'h0);
        drive(0, 0, 0, 1, 1, 5'd12, 2'b00, 3'd0, 32'hCAFE_0001, 32'h0, 32'h0);
        drive(0, 1, 1, 1, 1, 5'd13, 2'b00, 3'd0, 32'hCAFE_0002, 32'h0, 32'h0);
        drive(0, 0, 1, 1, 1, 5'd14, 2'b00, 3'd0, 32'hCAFE_0003, 32'h0, 32'h0);
        bubble();

        // counter from reset, wrap of the 2-bit instance, reset while WB holds rd=9
        drive(1, 0, 0, 0, 0, 5'd0, 2'b00, 3'd0, 32'h0, 32'h0, 32'h0);
        for (int i = 0; i < 5; i++)
            drive(0, 0, 0, 1, i[0], 5'(i + 1), 2'b00, 3'd0, 32'(i * 3), 32'h0, 32'h0);
        bubble();
        drive(0, 0, 0, 1, 1, 5'd9, 2'b00, 3'd0, 32'h0000_0099, 32'h0, 32'h0);
        drive(1, 0, 0, 1, 1, 5'd10, 2'b00, 3'd0, 32'h0000_00AA, 32'h0, 32'h0);
        bubble();

        // random traffic
        for (int i = 0; i < 80; i++) begin
            drive(($urandom_range(0, 24) == 0), ($urandom_range(0, 4) == 0),
                  ($urandom_range(0, 5) == 0), ($urandom_range(0, 7) != 0),
                  1'($urandom), 5'($urandom), 2'($urandom), 3'($urandom_range(0, 7)),
                  $urandom, $urandom, $urandom);
        end
        bubble();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/mips_writeback.md
Name: mips_writeback

Overview:
- MEM/WB pipeline stage and write-back unit of the MIPS pipeline.
- Registers the MEM-stage result and selects the write-back source: ALU result, aligned/extended load data, or link address.
- Drives the register file's single write port (reg_write, wdata, write). This block is the writer for that port.
- Flags misaligned loads and optionally counts retired instructions.

Parameters:
- BIG_ENDIAN, 1, byte-lane order for sub-word loads. 1 = byte at addr offset 0 is bits 31:24; 0 = bits 7:0.
- CNT_W, 32, width of the retire counter.

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  reset, synchronous, active-high
- stall  input  1  MEM stage frozen this cycle; WB captures a bubble
- flush  input  1  squash the instruction in MEM; WB captures a bubble
- mem_valid  input  1  MEM holds a real instruction
- mem_regwrite  input  1  instruction writes a GPR
- mem_rd  input  5  destination register
- mem_wbsel  input  2  source select: 00 ALU, 01 load, 10 link (pc+8), 11 reserved (treated as ALU)
- mem_load_type  input  3  000 LW, 001 LH, 010 LHU, 011 LB, 100 LBU; others treated as LW
- mem_alu_result  input  32  ALU result; for loads, the effective address
- mem_load_data  input  32  raw aligned word from data memory
- mem_pc_plus8  input  32  link address
- reg_write  output  5  register file write address
- wdata  output  32  register file write data
- write  output  1  register file write enable
- wb_valid  output  1  WB holds a real instruction
- wb_exc  output  1  misaligned-load exception for the WB instruction
- retire_count  output  CNT_W  instructions retired

Behaviour:
- Reset (rst=1 at a clk edge):
  - WB register cleared: valid=0, regwrite=0, rd=0, all data 0.
  - Outputs: reg_write=0, wdata=0, write=0, wb_valid=0, wb_exc=0, retire_count=0.
- Capture: at each clk edge with rst=0:
  - If stall or flush is high, WB loads a bubble (valid=0, regwrite=0, rd=0).
  - Otherwise WB loads all mem_* fields, with valid=mem_valid.
  - stall and flush together also produce a bubble.
  - The data fields of a bubble are don't-care, but they are cleared to 0.
- Latency: MEM inputs appear on the write port one cycle after capture. The write port is combinational from the WB register, with no extra cycle.
- Sub-word extraction uses off = alu_result[1:0].
  - Byte lane: BIG_ENDIAN=1 selects bits [31-8*off -: 8]; BIG_ENDIAN=0 selects bits [8*off +: 8].
  - Halfword lane: selected by off[1], with the same endianness rule.
  - LB and LH sign-extend to 32 bits. LBU and LHU zero-extend. LW passes the word unchanged.
- Misalignment:
  - LH/LHU is misaligned when off[0]=1.
  - LW is misaligned when off!=0.
  - LB/LBU are never misaligned.
  - wb_exc = wb_valid & (wbsel==01) & misaligned.
- wdata selection:
  - ALU source (00 or 11): alu_result.
  - Load source (01): extracted load value.
  - Link source (10): pc_plus8.
  - Bubble: 0.
- reg_write = rd of the WB register.
- write = wb_valid & regwrite & (rd!=0) & ~wb_exc.
  - rd=0 never asserts write.
  - A misaligned load never writes.
- Each WB instruction is presented for exactly one cycle. No back-pressure exists on the register file port.
- Retire: an instruction retires when wb_valid=1 and wb_exc=0, whether or not it writes. retire_count increments by 1 per retiring cycle and wraps modulo 2^CNT_W.
- Reset mid-operation: an instruction held in WB is discarded without writing in the cycle after the reset edge.

Optional Feature:
- Macro: MIPS_WB_RETIRE_CNT_EN.
- Defined: retire_count is implemented as described above.
- Not defined: no counter flops exist and retire_count is constant 0.
- All other behaviour is identical in both cases.

Test Plan:
- ALU write: mem_valid=1, regwrite=1, rd=5, wbsel=00, alu_result=0x0000_1234, edge -> next cycle write=1, reg_write=5, wdata=0x0000_1234; the cycle after, write=0 if MEM held a bubble.
- Sub-word loads, BIG_ENDIAN=1, load_data=0x80FF_7F01:
  - LB at addr 0x100 -> wdata=0xFFFF_FF80.
  - LBU at addr 0x101 -> wdata=0x0000_00FF.
  - LH at addr 0x102 -> wdata=0x0000_7F01.
  - LHU at addr 0x100 -> wdata=0x0000_80FF.
  - LW at addr 0x104 -> wdata=0x80FF_7F01.
- Misaligned: LW at addr 0x102, rd=7 -> wb_exc=1 for one cycle, write=0, retire_count unchanged; LH at addr 0x103 behaves the same.
- Link and r0: wbsel=10, pc_plus8=0x0040_0008, rd=31 -> write=1, wdata=0x0040_0008; same instruction with rd=0 -> write=0, retire_count still increments.
- Stall/flush: valid ALU instruction with stall=1 -> next cycle wb_valid=0, write=0; stall=0 on the following edge -> instruction written one cycle later. flush=1 and stall=1 together -> bubble.
- Reset and counter: retire 3 instructions -> retire_count=3; rst=1 while WB holds rd=9 -> next cycle write=0, retire_count=0. With CNT_W=2, retire 5 instructions -> retire_count=1. Without the macro -> retire_count stays 0.
